// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command byte transmitter driving open-drain clock/data enables
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int RTS_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_LEN     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    output logic       busy,
    output logic       rx_inhibit,
    output logic       done,
    output logic       ack_ok,
    output logic       err_noack,
    output logic       err_timeout
);
    localparam int M1   = INHIBIT_CYCLES > RTS_CYCLES ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int MAXC = M1 > TIMEOUT_CYCLES ? M1 : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT} state_t;

    state_t                r_state, w_next;
    logic [1:0]            r_clk_s, r_dat_s;
    logic [FILTER_LEN-1:0] r_hist;
    logic                  r_clk_f;
    logic [CW-1:0]         r_cnt;
    logic [3:0]            r_bits;
    logic [7:0]            r_data;
    logic                  r_par, r_dbit, r_ackd;
    logic                  r_done, r_ack_ok, r_noack, r_tout;
    logic                  w_fall, w_accept, w_to, w_live;

    assign w_accept = r_state == S_IDLE && tx_valid;
    assign w_live   = r_state == S_SEND || r_state == S_ACK;
    assign w_to     = w_live && r_cnt == CW'(TIMEOUT_CYCLES - 1);
    assign w_fall   = r_clk_f && ~|r_hist;

    // synchronise both pads and debounce the clock into a filtered level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_s <= '1;
            r_dat_s <= '1;
            r_hist  <= '1;
            r_clk_f <= 1'b1;
        end else begin
            r_clk_s <= {r_clk_s[0], ps2clk_in};
            r_dat_s <= {r_dat_s[0], ps2data_in};
            r_hist  <= {r_hist[FILTER_LEN-2:0], r_clk_s[1]};
            r_clk_f <= &r_hist ? 1'b1 : (~|r_hist ? 1'b0 : r_clk_f);
        end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // next-state logic; timeout overrides any fall seen in the same cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = tx_valid ? S_INHIBIT : S_IDLE;
            S_INHIBIT: w_next = r_cnt == CW'(INHIBIT_CYCLES - 1) ? S_RTS : S_INHIBIT;
            S_RTS:     w_next = r_cnt == CW'(RTS_CYCLES - 1) ? S_SEND : S_RTS;
            S_SEND:    w_next = w_to ? S_IDLE : (w_fall && r_bits == 4'd9 ? S_ACK : S_SEND);
            S_ACK:     w_next = w_to ? S_IDLE : (w_fall ? S_WAIT : S_ACK);
            S_WAIT:    w_next = r_clk_s[1] && r_dat_s[1] ? S_IDLE : S_WAIT;
            default:   w_next = S_IDLE;
        endcase
    end

    // phase/timeout counter, bit shifting, ack capture and status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_bits   <= '0;
            r_data   <= '0;
            r_par    <= 1'b0;
            r_dbit   <= 1'b1;
            r_ackd   <= 1'b0;
            r_done   <= 1'b0;
            r_ack_ok <= 1'b0;
            r_noack  <= 1'b0;
            r_tout   <= 1'b0;
        end else begin
            r_cnt   <= (r_state == S_IDLE || (r_state != w_next && w_next != S_ACK)) ? '0 : r_cnt + 1'b1;
            r_done  <= 1'b0;
            r_noack <= 1'b0;
            r_tout  <= 1'b0;
            if (w_accept) begin
                r_data   <= tx_data;
                r_par    <= ~^tx_data;
                r_bits   <= '0;
                r_dbit   <= 1'b0;
                r_ackd   <= 1'b0;
                r_ack_ok <= 1'b0;
            end
            if (w_live && w_fall && !w_to) r_bits <= r_bits + 1'b1;
            if (r_state == S_SEND && w_fall && !w_to)
                r_dbit <= r_bits < 4'd8 ? r_data[r_bits[2:0]] : (r_bits == 4'd8 ? r_par : 1'b1);
            if (r_state == S_ACK && w_fall && !w_to) r_ackd <= ~r_dat_s[1];
            if (w_to) begin
                r_done <= 1'b1;
                r_tout <= 1'b1;
            end
            if (r_state == S_WAIT && w_next == S_IDLE) begin
                r_done   <= 1'b1;
                r_ack_ok <= r_ackd;
                r_noack  <= ~r_ackd;
            end
        end
    end

    // line enables and status outputs decoded from state
    always_comb begin
        tx_ready    = r_state == S_IDLE;
        busy        = r_state != S_IDLE;
        rx_inhibit  = r_state != S_IDLE;
        ps2clk_oe   = r_state == S_INHIBIT || r_state == S_RTS;
        ps2data_oe  = r_state == S_RTS || (r_state == S_SEND && !r_dbit);
        done        = r_done;
        ack_ok      = r_ack_ok;
        err_noack   = r_noack;
        err_timeout = r_tout;
    end
endmodule
